// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses into single, double, long and auto-repeat pulses.
module button_event_decoder #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DCLICK_CYC = 15_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int CW         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic btn_tick,
  output logic single_tick,
  output logic double_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_single, r_double, r_long, r_repeat;
  assign single_tick = r_single;
  assign double_tick = r_double;
  assign long_tick   = r_long;
  assign repeat_tick = r_repeat;
  assign busy        = r_state != IDLE;
  // Releases and second presses are checked before expiry so they win same-cycle races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      case (r_state)
        IDLE: if (btn_tick) begin
          r_state <= PRESS1;
          r_cnt   <= '0;
        end
        PRESS1: if (!btn_level) begin
          r_state <= WAIT2;
          r_cnt   <= '0;
        end else if (r_cnt == LONG_LAST) begin
          r_state <= LONG;
          r_cnt   <= '0;
          r_long  <= 1'b1;
        end
        WAIT2: if (btn_tick) begin
          r_state  <= PRESS2;
          r_cnt    <= '0;
          r_double <= 1'b1;
        end else if (r_cnt == DCLICK_LAST) begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_single <= 1'b1;
        end
        PRESS2: if (!btn_level) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        LONG: if (!btn_level) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else if (r_cnt == REPEAT_LAST) begin
          r_cnt    <= '0;
          r_repeat <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: deadline-based reference model checked every cycle, plus literal pulse timings.
module tb_button_event_decoder;
  localparam int LC = 20, DC = 10, RC = 5;
  logic clk = 1'b0, rst_n = 1'b0, btn_level = 1'b0, btn_tick = 1'b0;
  logic single_tick, double_tick, long_tick, repeat_tick, busy;
  int cyc = 0, vectors = 0, miscompares = 0;
  int n_s, n_d, n_l, n_r, at_s, at_d, at_l, first_r, last_r;
  int mode = 0, dl = 0, t0, r, p;
  logic [4:0] exp_o = '0, got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_decoder #(.LONG_CYC(LC), .DCLICK_CYC(DC), .REPEAT_CYC(RC), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_tick(btn_tick),
    .single_tick(single_tick), .double_tick(double_tick), .long_tick(long_tick),
    .repeat_tick(repeat_tick), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic drive(input logic lvl, input logic tk);
    @(posedge clk);
    #2;
    btn_level = lvl;
    btn_tick  = tk;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic clear_log;
    n_s = 0; n_d = 0; n_l = 0; n_r = 0;
    at_s = -1; at_d = -1; at_l = -1; first_r = -1; last_r = -1;
  endtask

  // Model: each phase has an absolute expiry cycle; a pulse appears the cycle after its decision.
  task automatic compare_loop;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mode  = 0;
        exp_o = '0;
      end
      got = {single_tick, double_tick, long_tick, repeat_tick, busy};
      chk("outputs{s,d,l,r,busy}", int'(got), int'(exp_o));
      chk("one_hot_ticks", int'($countones(got[4:1]) > 1), 0);
      if (single_tick) begin n_s++; at_s = cyc; end
      if (double_tick) begin n_d++; at_d = cyc; end
      if (long_tick) begin n_l++; at_l = cyc; end
      if (repeat_tick) begin
        if (n_r == 0) first_r = cyc;
        n_r++;
        last_r = cyc;
      end
      if (rst_n) begin
        exp_o = '0;
        case (mode)
          0: if (btn_tick) begin mode = 1; dl = cyc + LC; end
          1: if (!btn_level) begin mode = 2; dl = cyc + DC; end
             else if (cyc == dl) begin mode = 4; dl = cyc + RC; exp_o[2] = 1'b1; end
          2: if (btn_tick) begin mode = 3; exp_o[3] = 1'b1; end
             else if (cyc == dl) begin mode = 0; exp_o[4] = 1'b1; end
          3: if (!btn_level) mode = 0;
          4: if (!btn_level) mode = 0;
             else if (cyc == dl) begin dl = cyc + RC; exp_o[1] = 1'b1; end
          default: mode = 0;
        endcase
        exp_o[0] = mode != 0;
      end
    end
  endtask

  initial begin
    fork
      compare_loop();
    join_none
    clear_log();
    #1;
    chk("reset_state", int'({single_tick, double_tick, long_tick, repeat_tick, busy}), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    // single click
    clear_log();
    drive(1'b1, 1'b1);
    repeat (4) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    r = cyc;
    idle(15);
    chk("single_count", n_s, 1);
    chk("single_at", at_s, r + 11);
    chk("single_others", n_d + n_l + n_r, 0);
    // double click
    clear_log();
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    r = cyc;
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    p = cyc;
    drive(1'b1, 1'b0);
    chk("double_busy", int'(busy), 1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle(15);
    chk("double_count", n_d, 1);
    chk("double_at", at_d, r + 5);
    chk("double_no_single", n_s + n_l + n_r, 0);
    // long press with ignored ticks while held
    clear_log();
    drive(1'b1, 1'b1);
    t0 = cyc;
    for (int i = 1; i < 40; i++) drive(1'b1, i == 10 || i == 30);
    drive(1'b0, 1'b0);
    idle(15);
    chk("long_count", n_l, 1);
    chk("long_at", at_l, t0 + 21);
    chk("repeat_count", n_r, 3);
    chk("repeat_first", first_r, t0 + 26);
    chk("repeat_last", last_r, t0 + 36);
    chk("long_no_click", n_s + n_d, 0);
    // release on the long-expiry cycle
    clear_log();
    drive(1'b1, 1'b1);
    t0 = cyc;
    repeat (19) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    idle(15);
    chk("race_long_none", n_l + n_r, 0);
    chk("race_long_single", n_s, 1);
    chk("race_long_single_at", at_s, t0 + 31);
    // second press on the single-expiry cycle
    clear_log();
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    r = cyc;
    repeat (9) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    idle(15);
    chk("race_single_double", n_d, 1);
    chk("race_single_double_at", at_d, r + 11);
    chk("race_single_none", n_s, 0);
    // asynchronous reset mid-press
    clear_log();
    drive(1'b1, 1'b1);
    repeat (5) drive(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_async", int'({single_tick, double_tick, long_tick, repeat_tick, busy}), 0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    rst_n = 1'b1;
    idle(30);
    chk("reset_no_pulse", n_s + n_d + n_l + n_r, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
